costas_gain_scheduler: RTL
==========================

# costas_gain_scheduler

Loop-gain controller for the QPSK Costas loop. It watches the 58-bit phase-detector error that feeds the loop filter. It runs an acquire/verify/track state machine and drives the filter's proportional (c1) and integral (c2) right-shift amounts, so the filter uses wide gains during capture and narrow gains once locked. It also raises a lock indication for downstream symbol decision and framing logic.

## Interface
Parameters:
- ERR_W, 58: phase-error width, signed two's complement.
- ACQ_MIN, 2000: minimum samples spent in ACQ before lock qualification starts.
- LOCK_THR, 2^50: lock threshold. An error with |pd_err| < LOCK_THR is "small".
- LOCK_CNT, 256: consecutive small samples in VERIFY needed to enter TRACK.
- LOST_CNT, 64: consecutive large samples in TRACK that declare loss of lock.
- C1_SH_ACQ, 35; C2_SH_ACQ, 38: shifts used in ACQ and VERIFY.
- C1_SH_TRK, 38; C2_SH_TRK, 41: shifts used in TRACK.

Ports (clock and reset first):
- clk, in, 1: system clock. This is the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: sample strobe. pd_err is valid when en=1.
- force_acq, in, 1: synchronous request to restart acquisition.
- pd_err, in, ERR_W: phase-detector error, signed.
- c1_sh, out, 6: current proportional shift for the loop filter.
- c2_sh, out, 6: current integral shift for the loop filter.
- locked, out, 1: high while the FSM is in TRACK.
- state, out, 2: current state. ACQ=0, VERIFY=1, TRACK=2.
- gain_chg, out, 1: one-cycle pulse whenever c1_sh/c2_sh change value.

## Operation
- Magnitude: mag = |pd_err|. The most negative input saturates to 2^(ERR_W-1)-1. small = (mag < LOCK_THR). The comparison is unsigned on ERR_W-1 bits.
- Counters: dwell_cnt (16 b, saturating at ACQ_MIN) and run_cnt (16 b, saturating at max(LOCK_CNT,LOST_CNT)). Both advance only when en=1.
- ACQ:
  - dwell_cnt increments on every en sample.
  - When dwell_cnt reaches ACQ_MIN, go to VERIFY and clear run_cnt.
- VERIFY:
  - A small sample increments run_cnt. A large sample clears run_cnt and stays in VERIFY; there is no fallback to ACQ.
  - When the sample that makes run_cnt reach LOCK_CNT arrives, go to TRACK and clear run_cnt.
- TRACK:
  - A large sample increments run_cnt. A small sample clears run_cnt.
  - When run_cnt reaches LOST_CNT, go to ACQ and clear dwell_cnt and run_cnt.
- Shift mapping: ACQ and VERIFY use the ACQ shifts. TRACK uses the TRK shifts.
- gain_chg pulses on VERIFY→TRACK and on TRACK→ACQ. It also pulses on a force_acq that leaves TRACK. It does not pulse on ACQ→VERIFY.
- force_acq has the highest priority, above any en-driven transition in the same cycle. It sends the FSM to ACQ and clears both counters.
  - If the FSM is already in ACQ, force_acq still restarts dwell_cnt.
- en=0: state, counters and outputs hold. force_acq is still honoured.

## Timing
- All outputs are registered and take effect on the clk edge that samples the qualifying en sample, so latency is 1 cycle from input to output.
- Example: the LOCK_CNT-th consecutive small sample is presented at edge k. Then state=TRACK, locked=1, c1_sh=38, c2_sh=41 and gain_chg=1 are all visible after edge k. gain_chg drops after edge k+1.
- Reset values: state=ACQ, c1_sh=C1_SH_ACQ, c2_sh=C2_SH_ACQ, locked=0, gain_chg=0, all counters 0.
- Reset mid-operation returns the block to these values asynchronously. The filter sees the ACQ gains immediately.
- Counter saturation: an ACQ dwell with en stuck high never wraps. run_cnt never wraps while a state is waiting out a long streak.

## Structure
- A shared package costas_pkg holds:
  - the state encoding (ACQ/VERIFY/TRACK);
  - the default shift constants, also used by the loop filter;
  - ERR_W.
- One sub-module, costas_err_mag: the combinational saturating absolute value plus threshold compare. It is reused later by the carrier lock-detector.
- The FSM, counters and output registers live in the top module.

## Test plan
- Reset then en=1 with pd_err=0 constant:
  - state goes 0→1 after 2000 samples;
  - state goes 1→2 after 256 more samples, with locked=1, c1_sh=38, c2_sh=41 and one gain_chg pulse.
- In VERIFY, feed 200 small samples, 1 sample of 2^55, then 256 small samples: TRACK is entered only on the final sample, 457 samples after VERIFY entry.
- In TRACK, feed 63 samples of -2^55 then 1 small sample (no loss of lock), then 64 samples of -2^55: state becomes ACQ on the 64th, locked=0, shifts return to 35/38, one gain_chg pulse.
- pd_err=-2^57 (most negative) in VERIFY: it is treated as large and run_cnt clears.
- Toggle en at 50% duty through a full acquisition: transition sample counts match scenario 1, and all outputs hold in en=0 cycles.
- Assert force_acq in the same cycle as the LOCK_CNT-th small sample: the FSM ends in ACQ, locked stays 0, no gain_chg pulse. Assert rst_n low for 1 cycle while in TRACK: all outputs return to their reset values.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared Costas-loop definitions: state encoding, default loop-filter shifts and error width.
package costas_pkg;

    localparam int unsigned COSTAS_ERR_W = 58;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_VERIFY = 2'd1,
        ST_TRACK  = 2'd2
    } costas_state_e;

    localparam logic [5:0] C1_SH_ACQ_DEF = 6'd35;
    localparam logic [5:0] C2_SH_ACQ_DEF = 6'd38;
    localparam logic [5:0] C1_SH_TRK_DEF = 6'd38;
    localparam logic [5:0] C2_SH_TRK_DEF = 6'd41;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/costas_err_mag.sv
// Saturating |err| and "small error" compare against a lock threshold; purely combinational.
module costas_err_mag
    import costas_pkg::*;
#(
    parameter int unsigned         ERR_W    = COSTAS_ERR_W,
    parameter logic [ERR_W-2:0]    LOCK_THR = {{(ERR_W-2){1'b0}}, 1'b1} << 50
) (
    input  logic [ERR_W-1:0] err_i,
    output logic [ERR_W-2:0] mag_o,
    output logic             small_o
);

    logic             neg_max;
    logic [ERR_W-2:0] neg_lo;

    // Negating only the low bits yields the correct magnitude for every negative input
    // except the most negative one, which is caught separately and saturated.
    assign neg_max = err_i[ERR_W-1] && (err_i[ERR_W-2:0] == '0);
    assign neg_lo  = '0 - err_i[ERR_W-2:0];

    always_comb begin
        mag_o = err_i[ERR_W-2:0];
        if (neg_max) begin
            mag_o = '1;
        end else if (err_i[ERR_W-1]) begin
            mag_o = neg_lo;
        end
        small_o = (mag_o < LOCK_THR);
    end

endmodule

// File: rtl/costas_gain_scheduler.sv
// Costas loop gain controller: ACQ/VERIFY/TRACK lock FSM driving loop-filter shifts and lock flag.
module costas_gain_scheduler
    import costas_pkg::*;
#(
    parameter int unsigned      ERR_W     = COSTAS_ERR_W,
    parameter int unsigned      ACQ_MIN   = 2000,
    parameter logic [ERR_W-2:0] LOCK_THR  = {{(ERR_W-2){1'b0}}, 1'b1} << 50,
    parameter int unsigned      LOCK_CNT  = 256,
    parameter int unsigned      LOST_CNT  = 64,
    parameter logic [5:0]       C1_SH_ACQ = C1_SH_ACQ_DEF,
    parameter logic [5:0]       C2_SH_ACQ = C2_SH_ACQ_DEF,
    parameter logic [5:0]       C1_SH_TRK = C1_SH_TRK_DEF,
    parameter logic [5:0]       C2_SH_TRK = C2_SH_TRK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             force_acq,
    input  logic [ERR_W-1:0] pd_err,
    output logic [5:0]       c1_sh,
    output logic [5:0]       c2_sh,
    output logic             locked,
    output logic [1:0]       state,
    output logic             gain_chg
);

    localparam logic [15:0] ACQ_MIN_C  = 16'(ACQ_MIN);
    localparam logic [15:0] LOCK_CNT_C = 16'(LOCK_CNT);
    localparam logic [15:0] LOST_CNT_C = 16'(LOST_CNT);
    localparam logic [15:0] RUN_MAX_C  = 16'(max_u(LOCK_CNT, LOST_CNT));

    costas_state_e    state_q, state_d;
    logic [15:0]      dwell_q, dwell_d, dwell_inc;
    logic [15:0]      run_q, run_d, run_inc;
    logic [5:0]       c1_q, c1_d, c2_q, c2_d;
    logic             locked_q, locked_d;
    logic             gchg_q, gchg_d;
    logic [ERR_W-2:0] err_mag;
    logic             err_small;

    costas_err_mag #(
        .ERR_W    (ERR_W),
        .LOCK_THR (LOCK_THR)
    ) u_err_mag (
        .err_i   (pd_err),
        .mag_o   (err_mag),
        .small_o (err_small)
    );

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        run_d     = run_q;
        dwell_inc = (dwell_q < ACQ_MIN_C) ? dwell_q + 16'd1 : dwell_q;
        run_inc   = (run_q < RUN_MAX_C) ? run_q + 16'd1 : run_q;

        if (force_acq) begin
            state_d = ST_ACQ;
            dwell_d = '0;
            run_d   = '0;
        end else if (en) begin
            unique case (state_q)
                ST_ACQ: begin
                    dwell_d = dwell_inc;
                    if (dwell_inc >= ACQ_MIN_C) begin
                        state_d = ST_VERIFY;
                        run_d   = '0;
                    end
                end
                ST_VERIFY: begin
                    if (!err_small) begin
                        run_d = '0;
                    end else if (run_inc >= LOCK_CNT_C) begin
                        state_d = ST_TRACK;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                ST_TRACK: begin
                    if (err_small) begin
                        run_d = '0;
                    end else if (run_inc >= LOST_CNT_C) begin
                        state_d = ST_ACQ;
                        dwell_d = '0;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: state_d = ST_ACQ;
            endcase
        end

        // Outputs are derived from the next state so they update on the qualifying edge.
        locked_d = (state_d == ST_TRACK);
        c1_d     = locked_d ? C1_SH_TRK : C1_SH_ACQ;
        c2_d     = locked_d ? C2_SH_TRK : C2_SH_ACQ;
        gchg_d   = (c1_d != c1_q) || (c2_d != c2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACQ;
            dwell_q  <= '0;
            run_q    <= '0;
            c1_q     <= C1_SH_ACQ;
            c2_q     <= C2_SH_ACQ;
            locked_q <= 1'b0;
            gchg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            run_q    <= run_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            locked_q <= locked_d;
            gchg_q   <= gchg_d;
        end
    end

    assign state    = state_q;
    assign c1_sh    = c1_q;
    assign c2_sh    = c2_q;
    assign locked   = locked_q;
    assign gain_chg = gchg_q;

endmodule
